riscv_lsu: RTL and testbench
============================

Name: riscv_lsu

Overview:
Load/store unit sitting directly downstream of the ALU in RISCV_architecture; consumes the ALU result as the effective address plus MemRead/MemWrite, funct3 and rs2 data.
- Produces byte enables, a byte-lane-aligned store word and a sign/zero-extended load result.
- Runs a request/ready handshake to a variable-latency data memory and stalls the core until the access completes.

Parameters:
bitwidth, 32, data/address width (fixed at 32; byte-lane logic assumes 4 lanes)
TIMEOUT, 15, max BUSY cycles waiting for bus_ready (used only with LSU_TIMEOUT_EN)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
MemRead  input  1  load request from decode
MemWrite  input  1  store request from decode
funct3  input  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
address  input  32  effective address (ALU_Result)
store_data  input  32  rs2 value
stall  output  1  hold PC/pipeline while high
load_data  output  32  extended load result, valid in DONE
misaligned  output  1  one-cycle pulse: misaligned or illegal access, no bus access made
byte_enable  output  4  active lanes of current bus access
bus_req  output  1  memory request
bus_we  output  1  1 = write
bus_addr  output  32  word address ({address[31:2],2'b00})
bus_wdata  output  32  lane-aligned write data
bus_ready  input  1  memory completion, sampled only while bus_req=1
bus_rdata  input  32  read word, valid with bus_ready
bus_error  output  1  timeout pulse (LSU_TIMEOUT_EN only; tied 0 otherwise)

Behaviour:
- Reset (rst=1 at posedge): state IDLE; bus_req, bus_we, bus_addr, bus_wdata, byte_enable, load_data, misaligned, bus_error = 0. stall forced 0 while rst=1. rst mid-access aborts immediately; bus_req low the cycle after.
- FSM states: IDLE, BUSY, DONE.
- Request = MemRead | MemWrite. Both high: treated as a store.
- Illegal: funct3[1:0]==11, or load with funct3 110/111.
- Misaligned: halfword with address[0]=1; word with address[1:0]!=0.
- IDLE, legal aligned request:
  - stall=1 combinationally.
  - At posedge, register bus_addr, bus_we, byte_enable, bus_wdata, funct3 and address[1:0]; go BUSY with bus_req=1.
- IDLE, illegal/misaligned request: no stall, no bus access; misaligned=1 for the next cycle only; remain IDLE.
- BUSY: stall=1, bus_req=1, bus outputs held stable.
  - bus_ready=1 at posedge: capture the extended bus_rdata into load_data (loads only; stores leave load_data unchanged); go DONE; bus_req drops.
- DONE: stall=0, load_data valid; core advances at this edge; next state IDLE unconditionally. A request in DONE is not accepted (it belongs to the retiring instruction).
- Minimum latency is 3 cycles per access (IDLE detect, BUSY, DONE) with bus_ready high in the first BUSY cycle. Each extra wait cycle adds one.
- Byte enables: SB 4'b0001<<address[1:0]; SH 4'b0011<<address[1:0]; SW 4'b1111.
- Store data: SB byte replicated ×4; SH halfword replicated ×2; SW unchanged.
- Load extract: lane selected by the latched address[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- bus_ready while not BUSY is ignored.

Optional Feature:
LSU_TIMEOUT_EN
- Defined:
  - A 4-bit+ counter clears on BUSY entry and increments each BUSY cycle without bus_ready.
  - When it reaches TIMEOUT, go DONE with load_data=0 and bus_error=1 for that DONE cycle.
  - bus_ready arriving in the same cycle as the limit wins (normal completion, no error).
- Undefined: no counter; BUSY waits indefinitely; bus_error tied 0.

Test Plan:
1. SW address=0x100, store_data=0xDEADBEEF, bus_ready in 1st BUSY cycle -> bus_addr=0x100, byte_enable=1111, bus_wdata=0xDEADBEEF, bus_we=1; stall high exactly 2 cycles, low in DONE.
2. LB address=0x203, bus_rdata=0x80FF0012 -> load_data=0xFFFFFF80; LBU same -> 0x00000080; LH address=0x202 -> 0xFFFF80FF; LHU -> 0x000080FF.
3. SH address=0x06, store_data=0x1234ABCD, bus_ready delayed 3 cycles -> byte_enable=1100, bus_wdata=0xABCDABCD, bus_addr=0x04, outputs stable through BUSY, stall high 5 cycles.
4. LW address=0x102 -> misaligned=1 one cycle, bus_req never asserts, stall=0; funct3=011 load -> same response.
5. rst=1 during BUSY of a load -> next cycle bus_req=0, stall=0, state IDLE, load_data=0; a new LW at 0x10 then completes normally.
6. (LSU_TIMEOUT_EN) LW with bus_ready held 0 -> after 15 BUSY cycles: DONE, bus_error=1 one cycle, load_data=0, stall released.

Source files
------------

// File: rtl/riscv_lsu.sv
// rtl/riscv_lsu.sv - load/store unit with request/ready data-memory handshake
// Optional bus timeout enabled by defining LSU_TIMEOUT_EN.
module riscv_lsu #(
  parameter int bitwidth = 32,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                MemRead,
  input  logic                MemWrite,
  input  logic [2:0]          funct3,
  input  logic [bitwidth-1:0] address,
  input  logic [bitwidth-1:0] store_data,
  output logic                stall,
  output logic [bitwidth-1:0] load_data,
  output logic                misaligned,
  output logic [3:0]          byte_enable,
  output logic                bus_req,
  output logic                bus_we,
  output logic [bitwidth-1:0] bus_addr,
  output logic [bitwidth-1:0] bus_wdata,
  input  logic                bus_ready,
  input  logic [bitwidth-1:0] bus_rdata,
  output logic                bus_error
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic [bitwidth-1:0]  bus_addr_q, bus_addr_d;
  logic [bitwidth-1:0]  bus_wdata_q, bus_wdata_d;
  logic [bitwidth-1:0]  load_data_q, load_data_d;
  logic [3:0]           byte_enable_q, byte_enable_d;
  logic                 bus_we_q, bus_we_d;
  logic [2:0]           f3_q, f3_d;
  logic [1:0]           lane_q, lane_d;
  logic                 misaligned_q, misaligned_d;
  logic                 bus_error_q, bus_error_d;

  logic                 req, illegal, mis, accept;
  logic [3:0]           be_new;
  logic [bitwidth-1:0]  wdata_new, shifted, ext;

`ifdef LSU_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 16) ? 4 : $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
`endif

  always_comb begin
    req     = MemRead | MemWrite;
    // MemWrite wins when both are set, so only pure loads see the 11x check
    illegal = (funct3[1:0] == 2'b11) || (!MemWrite && funct3[2:1] == 2'b11);
    mis     = (funct3[1:0] == 2'b01 && address[0]) ||
              (funct3[1:0] == 2'b10 && address[1:0] != 2'b00);
    accept  = req && !illegal && !mis;

    case (funct3[1:0])
      2'b00:   begin be_new = 4'b0001 << address[1:0]; wdata_new = {4{store_data[7:0]}};  end
      2'b01:   begin be_new = 4'b0011 << address[1:0]; wdata_new = {2{store_data[15:0]}}; end
      default: begin be_new = 4'b1111;                 wdata_new = store_data;            end
    endcase

    shifted = bus_rdata >> {lane_q, 3'b000};
    case (f3_q)
      3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  ext = {24'd0, shifted[7:0]};
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  ext = {16'd0, shifted[15:0]};
      default: ext = bus_rdata;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    load_data_d   = load_data_q;
    byte_enable_d = byte_enable_q;
    bus_we_d      = bus_we_q;
    f3_d          = f3_q;
    lane_d        = lane_q;
    misaligned_d  = 1'b0;
    bus_error_d   = 1'b0;
    stall         = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
    cnt_inc = cnt_q + CW'(1);
`endif
    case (state_q)
      IDLE: begin
`ifdef LSU_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (accept) begin
          stall         = 1'b1;
          state_d       = BUSY;
          bus_addr_d    = {address[bitwidth-1:2], 2'b00};
          bus_we_d      = MemWrite;
          byte_enable_d = be_new;
          bus_wdata_d   = wdata_new;
          f3_d          = funct3;
          lane_d        = address[1:0];
        end else if (req) begin
          misaligned_d  = 1'b1;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (bus_ready) begin
          if (!bus_we_q) load_data_d = ext;
          state_d = DONE;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_inc == CW'(TIMEOUT)) begin
          load_data_d = '0;
          bus_error_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst) stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bus_addr_q    <= '0;
      bus_wdata_q   <= '0;
      load_data_q   <= '0;
      byte_enable_q <= '0;
      bus_we_q      <= 1'b0;
      f3_q          <= '0;
      lane_q        <= '0;
      misaligned_q  <= 1'b0;
      bus_error_q   <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      cnt_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      load_data_q   <= load_data_d;
      byte_enable_q <= byte_enable_d;
      bus_we_q      <= bus_we_d;
      f3_q          <= f3_d;
      lane_q        <= lane_d;
      misaligned_q  <= misaligned_d;
      bus_error_q   <= bus_error_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q         <= cnt_d;
`endif
    end
  end

  assign bus_req     = (state_q == BUSY);
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign byte_enable = byte_enable_q;
  assign load_data   = load_data_q;
  assign misaligned  = misaligned_q;
`ifdef LSU_TIMEOUT_EN
  assign bus_error   = bus_error_q;
`else
  assign bus_error   = 1'b0;
  logic unused_err;
  assign unused_err  = bus_error_q;
`endif

endmodule

// File: tb/tb_riscv_lsu.sv
// tb/tb_riscv_lsu.sv - self-checking bench for riscv_lsu
module tb_riscv_lsu;
  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst, MemRead, MemWrite, bus_ready;
  logic [2:0]  funct3;
  logic [31:0] address, store_data, bus_rdata;
  logic        stall, misaligned, bus_req, bus_we, bus_error;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic [3:0]  byte_enable;

  riscv_lsu #(.bitwidth(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .MemRead(MemRead), .MemWrite(MemWrite), .funct3(funct3),
    .address(address), .store_data(store_data), .stall(stall), .load_data(load_data),
    .misaligned(misaligned), .byte_enable(byte_enable), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int stall_seen;
  logic chk_en = 1'b0;

  logic        exp_stall = 0, exp_req = 0, exp_we = 0, exp_mis = 0, exp_err = 0;
  logic [3:0]  exp_be = 0;
  logic [31:0] exp_addr = 0, exp_wdata = 0, exp_ld = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", stall, exp_stall);
      check("bus_req", bus_req, exp_req);
      check("bus_we", bus_we, exp_we);
      check("misaligned", misaligned, exp_mis);
      check("bus_error", bus_error, exp_err);
      check("byte_enable", byte_enable, exp_be);
      check("bus_addr", bus_addr, exp_addr);
      check("bus_wdata", bus_wdata, exp_wdata);
      check("load_data", load_data, exp_ld);
    end
  end

  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input int off);
    logic [3:0] be = 0;
    for (int l = 0; l < 4; l++) be[l] = (l >= off) && (l < off + nbytes(f3));
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] sd);
    logic [31:0] w;
    for (int l = 0; l < 4; l++) w[8*l +: 8] = sd[8*(l % nbytes(f3)) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input int off, input logic [31:0] rd);
    int n = nbytes(f3);
    logic [63:0] mask = (64'd1 << (8*n)) - 64'd1;
    logic [63:0] v = ({32'd0, rd} >> (8*off)) & mask;
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic logic m_ok(input logic wr, input logic [2:0] f3, input logic [31:0] a);
    if (f3[1:0] == 2'b11) return 1'b0;
    if (!wr && f3[2:1] == 2'b11) return 1'b0;
    return (a % nbytes(f3)) == 0;
  endfunction

  task automatic step();
    @(negedge clk);
    if (stall === 1'b1) stall_seen++;
    @(posedge clk);
    #1;
  endtask

  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] sd,
                        input logic [31:0] rdata, input int wait_n);
    logic ok, tmo;
    int busy_n;
    ok = m_ok(wr, f3, addr);
    stall_seen = 0;
    MemRead = rd; MemWrite = wr; funct3 = f3; address = addr; store_data = sd;
    bus_ready = 0; bus_rdata = rdata;
    exp_mis = 0; exp_err = 0; exp_req = 0; exp_stall = ok;
    if (!ok) begin
      step();
      MemRead = 0; MemWrite = 0; exp_mis = 1; exp_stall = 0;
      step();
      exp_mis = 0;
      return;
    end
    step();
`ifdef LSU_TIMEOUT_EN
    tmo = (wait_n + 1 > TO);
`else
    tmo = 1'b0;
`endif
    busy_n = tmo ? TO : wait_n + 1;
    exp_req = 1; exp_we = wr; exp_addr = {addr[31:2], 2'b00};
    exp_be = m_be(f3, int'(addr[1:0])); exp_wdata = m_wdata(f3, sd); exp_stall = 1;
    for (int i = 0; i < busy_n; i++) begin
      bus_ready = (i == wait_n);
      step();
    end
    bus_ready = 0;
    exp_req = 0; exp_stall = 0;
    if (tmo) begin
      exp_err = 1; exp_ld = 0;
    end else if (!wr) begin
      exp_ld = m_load(f3, int'(addr[1:0]), rdata);
    end
    step();
    MemRead = 0; MemWrite = 0; exp_err = 0;
  endtask

  initial begin
    rst = 1; MemRead = 0; MemWrite = 0; funct3 = 0; address = 0; store_data = 0;
    bus_ready = 0; bus_rdata = 0;
    @(posedge clk); @(posedge clk); #1;
    chk_en = 1;
    step();
    rst = 0;
    step();

    access(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0);
    check("sw_stall_cycles", stall_seen, 2);
    check("sw_wdata_lit", bus_wdata, 32'hDEADBEEF);

    bus_ready = 1; bus_rdata = 32'h5555AAAA;
    step();
    bus_ready = 0;

    access(1, 0, 3'b000, 32'h203, 0, 32'h80FF0012, 0);
    check("lb_lit", load_data, 32'hFFFFFF80);
    access(1, 0, 3'b100, 32'h203, 0, 32'h80FF0012, 0);
    check("lbu_lit", load_data, 32'h00000080);
    access(1, 0, 3'b001, 32'h202, 0, 32'h80FF0012, 1);
    check("lh_lit", load_data, 32'hFFFF80FF);
    access(1, 0, 3'b101, 32'h202, 0, 32'h80FF0012, 0);
    check("lhu_lit", load_data, 32'h000080FF);
    access(1, 0, 3'b010, 32'h300, 0, 32'hCAFEF00D, 2);
    check("lw_lit", load_data, 32'hCAFEF00D);
    access(1, 0, 3'b000, 32'h301, 0, 32'h11227F44, 0);
    check("lb_pos_lit", load_data, 32'h0000007F);

    access(0, 1, 3'b001, 32'h06, 32'h1234ABCD, 32'h0, 3);
    check("sh_stall_cycles", stall_seen, 5);
    check("sh_be_lit", byte_enable, 4'b1100);
    check("sh_wdata_lit", bus_wdata, 32'hABCDABCD);
    access(1, 1, 3'b000, 32'h09, 32'h000000E7, 32'h0, 0);
    check("sb_both_be_lit", byte_enable, 4'b0010);
    check("sb_both_wdata_lit", bus_wdata, 32'hE7E7E7E7);

    access(1, 0, 3'b010, 32'h102, 0, 32'h0, 0);
    check("lw_mis_stall", stall_seen, 0);
    access(1, 0, 3'b011, 32'h100, 0, 32'h0, 0);
    access(1, 0, 3'b110, 32'h100, 0, 32'h0, 0);
    access(0, 1, 3'b001, 32'h101, 32'h1, 32'h0, 0);

    MemRead = 1; funct3 = 3'b010; address = 32'h40; bus_rdata = 32'h87654321;
    exp_stall = 1; exp_req = 0;
    step();
    exp_req = 1; exp_we = 0; exp_addr = 32'h40; exp_be = 4'hF; exp_wdata = m_wdata(3'b010, store_data);
    step();
    rst = 1; exp_stall = 0;
    step();
    rst = 0; MemRead = 0;
    exp_req = 0; exp_addr = 0; exp_be = 0; exp_wdata = 0; exp_we = 0; exp_ld = 0;
    step();
    access(1, 0, 3'b010, 32'h10, 0, 32'h0BADF00D, 1);
    check("lw_after_rst_lit", load_data, 32'h0BADF00D);

    access(1, 0, 3'b010, 32'h20, 0, 32'h13579BDF, 20);
`ifdef LSU_TIMEOUT_EN
    check("timeout_stall_cycles", stall_seen, 16);
    check("timeout_ld_lit", load_data, 32'h0);
    access(1, 0, 3'b010, 32'h24, 0, 32'h2468ACE0, 14);
    check("ready_at_limit_lit", load_data, 32'h2468ACE0);
`else
    check("long_wait_stall_cycles", stall_seen, 22);
    check("long_wait_ld_lit", load_data, 32'h13579BDF);
`endif

    step();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
